// File: rtl/simple_bus_xbar.sv
// simple_bus_xbar: fixed-priority host arbitration, base/mask address decode,
// request forwarding to devices and one-cycle-later response routing back to
// the originating host. Unmapped accesses get a locally generated error response.
module simple_bus_xbar #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic [NrHosts-1:0]        host_req_i,
    output logic [NrHosts-1:0]        host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]        host_err_o,

    output logic [NrDevices-1:0]      device_req_o,
    output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    input  logic [NrDevices-1:0]      device_err_i,

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic                    any_req;
    logic [HostIdxW-1:0]     win_idx;
    logic [AddressWidth-1:0] fwd_addr;
    logic                    fwd_we;
    logic [DataWidth/8-1:0]  fwd_be;
    logic [DataWidth-1:0]    fwd_wdata;

    logic                    dev_hit;
    logic [DevIdxW-1:0]      dev_idx;

    logic [HostIdxW-1:0]     host_q, host_d;
    logic [DevIdxW-1:0]      dev_q, dev_d;
    logic                    miss_q, miss_d;

    // Lowest-index requester wins; its fields are forwarded (host 0 when idle).
    always_comb begin
        any_req    = 1'b0;
        win_idx    = '0;
        host_gnt_o = '0;
        fwd_addr   = host_addr_i[0];
        fwd_we     = host_we_i[0];
        fwd_be     = host_be_i[0];
        fwd_wdata  = host_wdata_i[0];
        for (int h = 0; h < NrHosts; h++) begin
            if (host_req_i[h] && !any_req) begin
                any_req       = 1'b1;
                win_idx       = HostIdxW'(h);
                host_gnt_o[h] = 1'b1;
                fwd_addr      = host_addr_i[h];
                fwd_we        = host_we_i[h];
                fwd_be        = host_be_i[h];
                fwd_wdata     = host_wdata_i[h];
            end
        end
    end

    // Address decode against base/mask; lowest matching device wins on overlap.
    always_comb begin
        dev_hit = 1'b0;
        dev_idx = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!dev_hit && ((fwd_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
                dev_hit = 1'b1;
                dev_idx = DevIdxW'(d);
            end
        end
    end

    // Drive the request to the matched device only; payload goes to every port.
    always_comb begin
        device_req_o = '0;
        device_we_o  = '0;
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = any_req && dev_hit && (dev_idx == DevIdxW'(d));
            device_addr_o[d]  = fwd_addr;
            device_we_o[d]    = fwd_we;
            device_be_o[d]    = fwd_be;
            device_wdata_o[d] = fwd_wdata;
        end
    end

    // Capture who asked and where it went on every granted cycle; a miss lasts one cycle.
    always_comb begin
        host_d = host_q;
        dev_d  = dev_q;
        miss_d = 1'b0;
        if (any_req) begin
            host_d = win_idx;
            dev_d  = dev_idx;
            miss_d = !dev_hit;
        end
    end

    // Response tracking registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            host_q <= '0;
            dev_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            host_q <= host_d;
            dev_q  <= dev_d;
            miss_q <= miss_d;
        end
    end

    // Route the device response (or the local miss error) back to the recorded host.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = '0;
            if (host_q == HostIdxW'(h)) begin
                if (miss_q) begin
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = 1'b1;
                end else begin
                    for (int d = 0; d < NrDevices; d++) begin
                        if ((dev_q == DevIdxW'(d)) && device_rvalid_i[d]) begin
                            host_rvalid_o[h] = 1'b1;
                            host_rdata_o[h]  = device_rdata_i[d];
                            host_err_o[h]    = device_err_i[d];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_simple_bus_xbar.sv
// Testbench for simple_bus_xbar: two hosts, three devices (RAM, sim control, timer).
module tb_simple_bus_xbar;

   localparam int NH = 2;
   localparam int ND = 3;

   logic        clk;
   logic        rst_n;
   logic [1:0]  host_req;
   logic [1:0]  host_gnt;
   logic [31:0] host_addr [NH];
   logic [1:0]  host_we;
   logic [3:0]  host_be [NH];
   logic [31:0] host_wdata [NH];
   logic [1:0]  host_rvalid;
   logic [31:0] host_rdata [NH];
   logic [1:0]  host_err;
   logic [2:0]  dev_req;
   logic [31:0] dev_addr [ND];
   logic [2:0]  dev_we;
   logic [3:0]  dev_be [ND];
   logic [31:0] dev_wdata [ND];
   logic [2:0]  dev_rvalid;
   logic [31:0] dev_rdata [ND];
   logic [2:0]  dev_err;
   logic [31:0] cfg_base [ND];
   logic [31:0] cfg_mask [ND];

   int compared = 0;
   int mismatched = 0;

   simple_bus_xbar #(
      .NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
      .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
      .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
      .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
      .device_be_o(dev_be), .device_wdata_o(dev_wdata),
      .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
      .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  req;
      logic [31:0] addr0;
      logic [31:0] addr1;
      logic [1:0]  expGnt;
      logic [2:0]  expDevReq;
      logic [31:0] expAddr;
   } vec_t;

   vec_t vecs [9];

   // Drive the host-side request fields.
   task automatic applyStimulus(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                                input logic we0, input logic [31:0] wd0);
      host_req      = req;
      host_addr[0]  = a0;
      host_addr[1]  = a1;
      host_we       = {1'b0, we0};
      host_be[0]    = 4'hF;
      host_be[1]    = 4'hF;
      host_wdata[0] = wd0;
      host_wdata[1] = 32'h0;
   endtask

   // Compare one observed value with its expected value and log failures.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Quiet all device responses.
   task automatic clearResponses();
      dev_rvalid = 3'b000;
      dev_err    = 3'b000;
      for (int d = 0; d < ND; d++) dev_rdata[d] = 32'h0;
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // RAM, simulator control, timer.
      cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
      cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_0000;
      cfg_base[2] = 32'h0030_0000; cfg_mask[2] = 32'hFFFF_F000;

      vecs[0] = '{2'b01, 32'h0010_0040, 32'h0, 2'b01, 3'b001, 32'h0010_0040};
      vecs[1] = '{2'b01, 32'h0002_0000, 32'h0, 2'b01, 3'b010, 32'h0002_0000};
      vecs[2] = '{2'b01, 32'h0030_0004, 32'h0, 2'b01, 3'b100, 32'h0030_0004};
      vecs[3] = '{2'b01, 32'h0000_0000, 32'h0, 2'b01, 3'b000, 32'h0000_0000};
      vecs[4] = '{2'b11, 32'h0010_0040, 32'h0030_0004, 2'b01, 3'b001, 32'h0010_0040};
      vecs[5] = '{2'b10, 32'h0010_0040, 32'h0030_0004, 2'b10, 3'b100, 32'h0030_0004};
      vecs[6] = '{2'b01, 32'h001F_FFFC, 32'h0, 2'b01, 3'b001, 32'h001F_FFFC};
      vecs[7] = '{2'b01, 32'h0020_0000, 32'h0, 2'b01, 3'b000, 32'h0020_0000};
      vecs[8] = '{2'b00, 32'h0002_0010, 32'h0030_0004, 2'b00, 3'b000, 32'h0002_0010};

      // Reset state: in-flight response from device 0 routes to host 0.
      rst_n = 1'b0;
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      clearResponses();
      dev_rvalid   = 3'b001;
      dev_rdata[0] = 32'h5A5A_5A5A;
      #3;
      checkOutput("reset_rvalid", 32'(host_rvalid), 32'h1);
      checkOutput("reset_rdata0", host_rdata[0], 32'h5A5A_5A5A);
      checkOutput("reset_rdata1", host_rdata[1], 32'h0);
      checkOutput("reset_err", 32'(host_err), 32'h0);
      clearResponses();
      #1;
      checkOutput("reset_idle_rvalid", 32'(host_rvalid), 32'h0);
      #8 rst_n = 1'b1;

      // Combinational arbitration and decode vectors.
      for (int i = 0; i < 9; i++) begin
         nextCycle();
         applyStimulus(vecs[i].req, vecs[i].addr0, vecs[i].addr1, 1'b0, 32'h0);
         #2;
         checkOutput($sformatf("vec%0d_gnt", i), 32'(host_gnt), 32'(vecs[i].expGnt));
         checkOutput($sformatf("vec%0d_devreq", i), 32'(dev_req), 32'(vecs[i].expDevReq));
         checkOutput($sformatf("vec%0d_addr", i), dev_addr[2], vecs[i].expAddr);
      end

      // Overlapping windows: lowest matching device wins.
      cfg_base[2] = 32'h0010_0000; cfg_mask[2] = 32'hFFF0_0000;
      nextCycle();
      applyStimulus(2'b01, 32'h0010_0040, 32'h0, 1'b0, 32'h0);
      #2;
      checkOutput("overlap_devreq", 32'(dev_req), 32'h1);
      cfg_base[2] = 32'h0030_0000; cfg_mask[2] = 32'hFFFF_F000;

      // RAM read with next-cycle data.
      nextCycle();
      applyStimulus(2'b01, 32'h0010_0040, 32'h0, 1'b0, 32'h0);
      #2;
      checkOutput("read_gnt", 32'(host_gnt), 32'h1);
      checkOutput("read_devreq", 32'(dev_req), 32'h1);
      checkOutput("read_addr", dev_addr[0], 32'h0010_0040);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      dev_rvalid = 3'b001; dev_rdata[0] = 32'hDEAD_BEEF;
      #2;
      checkOutput("read_rvalid", 32'(host_rvalid), 32'h1);
      checkOutput("read_rdata0", host_rdata[0], 32'hDEAD_BEEF);
      checkOutput("read_rdata1", host_rdata[1], 32'h0);
      clearResponses();

      // Write to simulator control.
      nextCycle();
      applyStimulus(2'b01, 32'h0002_0000, 32'h0, 1'b1, 32'h0000_0041);
      #2;
      checkOutput("write_devreq", 32'(dev_req), 32'h2);
      checkOutput("write_we", 32'(dev_we), 32'h7);
      checkOutput("write_wdata", dev_wdata[1], 32'h0000_0041);
      checkOutput("write_be", 32'(dev_be[1]), 32'hF);

      // Timer read returning an error.
      nextCycle();
      applyStimulus(2'b01, 32'h0030_0004, 32'h0, 1'b0, 32'h0);
      #2;
      checkOutput("timer_devreq", 32'(dev_req), 32'h4);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      dev_rvalid = 3'b100; dev_err = 3'b100;
      #2;
      checkOutput("timer_rvalid", 32'(host_rvalid), 32'h1);
      checkOutput("timer_err", 32'(host_err), 32'h1);
      clearResponses();

      // Unmapped access: one-cycle error response.
      nextCycle();
      applyStimulus(2'b01, 32'h0000_0000, 32'h0, 1'b0, 32'h0);
      #2;
      checkOutput("miss_gnt", 32'(host_gnt), 32'h1);
      checkOutput("miss_devreq", 32'(dev_req), 32'h0);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      #2;
      checkOutput("miss_rvalid", 32'(host_rvalid), 32'h1);
      checkOutput("miss_err", 32'(host_err), 32'h1);
      checkOutput("miss_rdata", host_rdata[0], 32'h0);
      nextCycle();
      #2;
      checkOutput("miss_clear_rvalid", 32'(host_rvalid), 32'h0);
      checkOutput("miss_clear_err", 32'(host_err), 32'h0);

      // Two hosts contend; host 1 is served the following cycle.
      nextCycle();
      applyStimulus(2'b11, 32'h0010_0040, 32'h0030_0004, 1'b0, 32'h0);
      #2;
      checkOutput("contend_gnt", 32'(host_gnt), 32'h1);
      nextCycle();
      applyStimulus(2'b10, 32'h0010_0040, 32'h0030_0004, 1'b0, 32'h0);
      dev_rvalid = 3'b001; dev_rdata[0] = 32'h1111_1111;
      #2;
      checkOutput("h1_gnt", 32'(host_gnt), 32'h2);
      checkOutput("h1_devreq", 32'(dev_req), 32'h4);
      checkOutput("h0_resp_rvalid", 32'(host_rvalid), 32'h1);
      checkOutput("h0_resp_rdata", host_rdata[0], 32'h1111_1111);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      clearResponses();
      dev_rvalid = 3'b100; dev_rdata[2] = 32'h2222_2222;
      #2;
      checkOutput("h1_resp_rvalid", 32'(host_rvalid), 32'h2);
      checkOutput("h1_resp_rdata1", host_rdata[1], 32'h2222_2222);
      checkOutput("h1_resp_rdata0", host_rdata[0], 32'h0);
      clearResponses();

      // Asynchronous reset while a miss response is pending.
      nextCycle();
      applyStimulus(2'b01, 32'h0000_0000, 32'h0, 1'b0, 32'h0);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      #1;
      checkOutput("pre_reset_rvalid", 32'(host_rvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_rvalid", 32'(host_rvalid), 32'h0);
      checkOutput("async_reset_err", 32'(host_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      nextCycle();
      applyStimulus(2'b01, 32'h0010_0080, 32'h0, 1'b0, 32'h0);
      #2;
      checkOutput("post_reset_gnt", 32'(host_gnt), 32'h1);
      checkOutput("post_reset_devreq", 32'(dev_req), 32'h1);
      nextCycle();
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
      dev_rvalid = 3'b001; dev_rdata[0] = 32'hCAFE_F00D;
      #2;
      checkOutput("post_reset_rvalid", 32'(host_rvalid), 32'h1);
      checkOutput("post_reset_rdata", host_rdata[0], 32'hCAFE_F00D);
      checkOutput("post_reset_err", 32'(host_err), 32'h0);
      clearResponses();

      nextCycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/simple_bus_xbar.md
Name: simple_bus_xbar

Overview:
- Single-cycle-grant memory-mapped interconnect connecting NrHosts request/response hosts (e.g. the core data port) to NrDevices memory-mapped devices (RAM, simulator control, timer).
- Arbitrates among hosts by fixed priority and decodes the winning address against per-device base/mask registers.
- Forwards the request to the selected device and routes the one-cycle-later response back to the originating host.

Parameters:
- NrDevices, 1, number of device ports.
- NrHosts, 1, number of host ports.
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- host_req_i  in  [NrHosts] x 1  host request.
- host_gnt_o  out  [NrHosts] x 1  grant; combinational, same cycle as the request.
- host_addr_i  in  [NrHosts] x AddressWidth  byte address.
- host_we_i  in  [NrHosts] x 1  write enable.
- host_be_i  in  [NrHosts] x DataWidth/8  byte enables.
- host_wdata_i  in  [NrHosts] x DataWidth  write data.
- host_rvalid_o  out  [NrHosts] x 1  response valid.
- host_rdata_o  out  [NrHosts] x DataWidth  read data.
- host_err_o  out  [NrHosts] x 1  response error.
- device_req_o  out  [NrDevices] x 1  device request.
- device_addr_o  out  [NrDevices] x AddressWidth  forwarded address.
- device_we_o  out  [NrDevices] x 1  forwarded write enable.
- device_be_o  out  [NrDevices] x DataWidth/8  forwarded byte enables.
- device_wdata_o  out  [NrDevices] x DataWidth  forwarded write data.
- device_rvalid_i  in  [NrDevices] x 1  device response valid.
- device_rdata_i  in  [NrDevices] x DataWidth  device read data.
- device_err_i  in  [NrDevices] x 1  device error.
- cfg_device_addr_base  in  [NrDevices] x AddressWidth  device base address.
- cfg_device_addr_mask  in  [NrDevices] x AddressWidth  device address mask.

Behaviour:
- Arbitration:
  - The lowest-index host with req=1 wins.
  - host_gnt_o[winner] = 1 combinationally; all other grants are 0.
  - Losing hosts hold their request until granted.
- Decode:
  - Device d matches when (addr & mask[d]) == base[d].
  - On overlap, the lowest matching index wins.
- Forwarding:
  - device_req_o[sel] = 1 only for the matched device while a winner exists.
  - addr/we/be/wdata of the winning host are driven to all device ports. With no requester, host 0's fields are driven.
- Response tracking: on each granted request, register the host index, device index and a "miss" flag (no device matched).
- Response latency: devices respond exactly one cycle after a granted request.
  - host_rvalid_o[h] = device_rvalid_i[dev_q] when h == host_q; rdata and err are routed the same way.
  - Non-selected hosts see rvalid=0, rdata=0, err=0.
- Unmapped address:
  - The request is granted and no device_req_o is asserted.
  - The next cycle, host_q receives rvalid=1, err=1, rdata=0.
  - The miss response is generated for exactly one cycle, then cleared.
- Back-to-back requests are allowed every cycle; registered selection updates on every granted cycle.
- Reset values:
  - host_q = 0, dev_q = 0, miss pending = 0.
  - All host_rvalid_o/host_err_o = 0 and host_rdata_o = 0 unless a device drives rvalid.
- Reset mid-transaction: the pending miss response is dropped; in-flight device responses still route to host 0/device 0.
- Widths: the mask compare uses the full AddressWidth; no address translation (the device sees the full host address).

Test Plan:
- Host 0 reads 0x0010_0040 with RAM base 0x0010_0000, mask 0xFFF0_0000 -> gnt same cycle; device_req_o[0]=1 with addr 0x0010_0040; next-cycle RAM rdata 0xDEADBEEF reaches host_rdata_o[0] with rvalid=1.
- Host 0 writes 0x0002_0000, be=4'hF, wdata 0x41 -> device_req_o[1]=1 only, we=1, wdata 0x41; no other device_req.
- Host 0 reads 0x0030_0004 (timer) while the timer returns err=1 -> host_err_o[0]=1 with rvalid the next cycle.
- Access to 0x0000_0000 (unmapped) -> gnt=1, no device_req; next cycle rvalid=1, err=1, rdata=0; one cycle later rvalid=0.
- NrHosts=2, both hosts request in the same cycle -> host 0 granted, host 1 gnt=0; host 1 is granted the next cycle and its response routes only to host 1.
- Assert rst_ni=0 asynchronously during a miss-pending cycle -> rvalid/err drop to 0 immediately; the first request after reset behaves normally.
